// File: rtl/fifo_parser_sync_pkg.sv
// fifo_parser_sync_pkg: read-mode encodings and constant helpers shared by the parser FIFO
package fifo_parser_sync_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_parser_sync_ram.sv
// fifo_parser_sync_ram: simple dual-port array, sync write, registered read with enable
module fifo_parser_sync_ram #(
  parameter int WIDTH = 85,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/fifo_parser_sync.sv
// fifo_parser_sync: parametrised single-clock FIFO with std/FWFT read, thresholds,
// occupancy count, overflow/underflow pulses and reset-busy handshake
import fifo_parser_sync_pkg::*;
module fifo_parser_sync #(
  parameter int WIDTH = 85,
  parameter int DEPTH = 8,
  parameter int FWFT = 0,
  parameter int PROG_FULL_THRESH = 3,
  parameter int PROG_EMPTY_THRESH = 1,
  parameter int RST_BUSY_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       prog_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       empty,
  output logic                       prog_empty,
  output logic [clog2(DEPTH):0]      data_count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       wr_rst_busy,
  output logic                       rd_rst_busy
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = clog2(RST_BUSY_CYCLES + 1);
  localparam bit FW = (FWFT == FIFO_FWFT);
  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH ||
      PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH >= DEPTH ||
      RST_BUSY_CYCLES < 1 || (FWFT != FIFO_STD && FWFT != FIFO_FWFT)) begin : g_bad_params
    $error("fifo_parser_sync: illegal parameter set");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic [BW-1:0] busy_cnt;
  logic busy, wr_acc, rd_acc, ram_re;
  assign busy = busy_cnt != '0;
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;
  // in FWFT mode the output register holds one word outside the array
  assign data_count = mem_cnt + CW'(FW & valid);
  assign full = busy | (data_count == CW'(DEPTH));
  assign empty = busy | (FW ? ~valid : (mem_cnt == '0));
  assign prog_full = data_count >= CW'(PROG_FULL_THRESH);
  assign prog_empty = data_count <= CW'(PROG_EMPTY_THRESH);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  // FWFT refills the head register whenever it is empty or being popped
  assign ram_re = FW ? (mem_cnt != '0) & (~valid | rd_acc) : rd_acc;
  fifo_parser_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .rst_n(rst_n), .we(wr_acc), .wa(wr_ptr), .wd(din),
    .re(ram_re), .ra(rd_ptr), .q(dout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_cnt <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      busy_cnt <= BW'(RST_BUSY_CYCLES);
    end else begin
      busy_cnt <= busy ? busy_cnt - 1'b1 : busy_cnt;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + CW'(wr_acc) - CW'(ram_re);
      valid <= FW ? (ram_re | (valid & ~rd_acc)) : rd_acc;
      overflow <= wr_en & full & ~busy;
      underflow <= rd_en & empty & ~busy;
    end
endmodule

// File: tb/tb_fifo_parser_sync.sv
// tb_fifo_parser_sync: directed checks of a standard-mode and an FWFT-mode FIFO instance
module tb_fifo_parser_sync;
  logic clk = 0, rst_n = 0;
  logic [84:0] din = '0, f_din = '0, dout, f_dout;
  logic wr_en = 0, rd_en = 0, f_wr = 0, f_rd = 0;
  logic full, prog_full, valid, empty, prog_empty, overflow, underflow, wr_busy, rd_busy;
  logic f_full, f_pfull, f_valid, f_empty, f_pempty, f_ovf, f_unf, f_wbusy, f_rbusy;
  logic [3:0] data_count, f_count;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fifo_parser_sync u_std (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full), .prog_full(prog_full),
    .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty), .prog_empty(prog_empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow),
    .wr_rst_busy(wr_busy), .rd_rst_busy(rd_busy)
  );
  fifo_parser_sync #(.FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .din(f_din), .wr_en(f_wr), .full(f_full), .prog_full(f_pfull),
    .rd_en(f_rd), .dout(f_dout), .valid(f_valid), .empty(f_empty), .prog_empty(f_pempty),
    .data_count(f_count), .overflow(f_ovf), .underflow(f_unf),
    .wr_rst_busy(f_wbusy), .rd_rst_busy(f_rbusy)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step;
    chk("rst_full", full, 1); chk("rst_empty", empty, 1); chk("rst_busy", {wr_busy, rd_busy}, 2'b11);
    chk("rst_pe", prog_empty, 1); chk("rst_pf", prog_full, 0); chk("rst_cnt", data_count, 0);
    chk("rst_valid", valid, 0); chk("rst_dout", dout, 0);
    rst_n = 1;
    step;
    chk("busy1", wr_busy, 1); chk("busy1_full", full, 1); chk("busy1_empty", empty, 1);
    step;
    chk("busy2", {wr_busy, rd_busy}, 2'b00); chk("rel_full", full, 0);
    chk("rel_empty", empty, 1); chk("rel_cnt", data_count, 0);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; din = 85'(i);
      step;
      chk("fill_cnt", data_count, i + 1); chk("fill_pf", prog_full, i >= 2);
      chk("fill_full", full, i == 7); chk("fill_ovf", overflow, 0);
    end
    din = 85'd8;
    step;
    chk("ovf_pulse", overflow, 1); chk("ovf_cnt", data_count, 8);
    wr_en = 0;
    step;
    chk("ovf_clear", overflow, 0);
    rd_en = 1;
    for (int j = 0; j < 8; j++) begin
      step;
      chk("drain_dout", dout, j); chk("drain_valid", valid, 1);
      chk("drain_pe", prog_empty, j >= 6);
    end
    rd_en = 0;
    step;
    chk("drain_valid_off", valid, 0); chk("drain_empty", empty, 1); chk("drain_hold", dout, 7);
    wr_en = 1; din = 85'hA;
    step;
    chk("we_empty_deassert", empty, 0);
    din = 85'hB;
    step;
    wr_en = 0; rd_en = 1;
    step;
    chk("rd_a", dout, 85'hA); chk("rd_a_valid", valid, 1);
    step;
    chk("rd_b", dout, 85'hB); chk("rd_b_valid", valid, 1);
    step;
    chk("unf_pulse", underflow, 1); chk("unf_valid", valid, 0); chk("unf_hold", dout, 85'hB);
    rd_en = 0;
    step;
    chk("unf_clear", underflow, 0);
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      din = 85'(i);
      step;
    end
    rd_en = 1;
    for (int i = 0; i < 20; i++) begin
      din = 85'(i + 5);
      step;
      chk("wrap_dout", dout, i); chk("wrap_cnt", data_count, 5);
    end
    rd_en = 0; din = 85'd99;
    step;
    chk("cnt6", data_count, 6);
    wr_en = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_cnt", data_count, 0); chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", valid, 0); chk("mid_rst_flags", {overflow, underflow, prog_full}, 0);
    step;
    rst_n = 1;
    step;
    step;
    chk("fw_ready", {f_wbusy, f_empty, f_valid}, 3'b010);
    f_wr = 1; f_din = 85'h55;
    step;
    f_wr = 0;
    step;
    chk("fw_valid", f_valid, 1); chk("fw_dout", f_dout, 85'h55);
    chk("fw_empty", f_empty, 0); chk("fw_cnt", f_count, 1);
    step;
    chk("fw_stable", f_dout, 85'h55);
    f_rd = 1;
    step;
    chk("fw_pop_empty", f_empty, 1); chk("fw_pop_valid", f_valid, 0); chk("fw_pop_cnt", f_count, 0);
    f_rd = 0; f_wr = 1;
    for (int i = 1; i <= 3; i++) begin
      f_din = 85'(i);
      step;
    end
    f_wr = 0;
    chk("fw3_cnt", f_count, 3); chk("fw3_head", f_dout, 1);
    f_rd = 1;
    step;
    chk("fw_b2b_2", f_dout, 2); chk("fw_b2b_cnt", f_count, 2);
    step;
    chk("fw_b2b_3", f_dout, 3); chk("fw_b2b_valid", f_valid, 1);
    step;
    chk("fw_drained", {f_valid, f_empty}, 2'b01);
    step;
    chk("fw_unf", f_unf, 1);
    f_rd = 0;
    step;
    chk("fw_unf_clear", f_unf, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
